ballot_unit: RTL and testbench
==============================

BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the number of stable sampled cycles required to accept a press.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the maximum number of cycles an issued ballot stays open without a vote.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ballot_issue, input, 1 bit: presiding-officer pulse that opens one ballot.
REQ-006 The block SHALL have port btn, input, 4 bits: raw asynchronous candidate buttons, bit k selects candidate k.
REQ-007 The block SHALL have port poll_close, input, 1 bit: level signal that ends polling.
REQ-008 The block SHALL have port vote_ready, input, 1 bit: the downstream vote counter accepts a vote.
REQ-009 The block SHALL have port vote_valid, output, 1 bit: a vote is offered to the counter.
REQ-010 The block SHALL have port vote_sel, output, 2 bits: candidate index of the offered vote.
REQ-011 The block SHALL have port ballot_lamp, output, 1 bit: a ballot is open (state ARMED or DEBOUNCE).
REQ-012 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when an open ballot expires.
REQ-013 The block SHALL have port total_votes, output, 16 bits: count of votes handed off to the counter.

Function
REQ-014 btn SHALL pass through a 2-flop synchroniser; all decisions SHALL use the synchronised value sb.
REQ-015 The FSM SHALL have exactly the states IDLE, ARMED, DEBOUNCE, COMMIT, RELEASE and CLOSED.
REQ-016 In IDLE, ballot_issue=1 SHALL move the FSM to ARMED; ballot_issue in any other state SHALL be ignored.
REQ-017 In ARMED, sb one-hot SHALL latch the candidate index, clear the debounce counter and move to DEBOUNCE; sb zero or multi-hot SHALL keep the FSM in ARMED.
REQ-018 In DEBOUNCE, sb equal to the latched one-hot SHALL increment the counter, and reaching DEBOUNCE_CYCLES SHALL move to COMMIT; any other sb SHALL return to ARMED with the counter cleared.
REQ-019 In COMMIT, vote_valid SHALL be 1 and vote_sel SHALL hold constant until a cycle with vote_ready=1, after which the FSM leaves COMMIT on the next edge.
REQ-020 Each COMMIT handshake SHALL increment total_votes exactly once, saturating at 16'hFFFF.
REQ-021 RELEASE SHALL wait until sb==0 and then go to IDLE, so that a held button can never cast a second vote.
REQ-022 poll_close=1 in IDLE, ARMED or DEBOUNCE SHALL move to CLOSED with no vote; in COMMIT the handshake SHALL complete first and the FSM SHALL then go to CLOSED instead of RELEASE; in RELEASE it SHALL go to CLOSED.
REQ-023 CLOSED SHALL be absorbing until reset, with vote_valid=0 and ballot_lamp=0.
REQ-024 Latency from a clean stable press to vote_valid SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-025 vote_valid SHALL be a registered output and SHALL be 0 outside COMMIT.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state=IDLE, synchroniser=0, counters=0, vote_valid=0, vote_sel=0, ballot_lamp=0, timeout=0 and total_votes=0.
REQ-027 Reset asserted mid-COMMIT SHALL drop vote_valid immediately and SHALL NOT count the vote.

Configuration
REQ-028 With macro BALLOT_TIMEOUT_EN defined, a counter SHALL start on entry to ARMED; when TIMEOUT_CYCLES elapse while in ARMED/DEBOUNCE the FSM SHALL return to IDLE and pulse timeout for 1 cycle.
REQ-029 Without BALLOT_TIMEOUT_EN, ballots SHALL stay open indefinitely and timeout SHALL be tied to 0.

Structure
REQ-030 Shared package evm_pkg SHALL hold the FSM state enum, NUM_CAND=4, CAND_W=2 and VOTE_CNT_W=16.
REQ-031 The synchroniser SHALL be a sub-module named btn_sync, parameterised by width.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-032 Issue, then hold btn=4'b0100 stable -> vote_valid at cycle 7 after the press with vote_sel=2; vote_ready=1 -> total_votes=1.
REQ-033 Issue, then btn=4'b0011 held, then 4'b0001 -> no vote while multi-hot; vote_sel=0 after a stable 4'b0001.
REQ-034 Button bounces 1,0,1 within 3 cycles -> FSM returns to ARMED and the debounce counter restarts; no premature vote_valid.
REQ-035 vote_ready held 0 for 10 cycles in COMMIT -> vote_valid and vote_sel stable throughout; button held after acceptance -> no second vote until release and a new issue.
REQ-036 With BALLOT_TIMEOUT_EN, issue and no press for 20 cycles -> single timeout pulse, state IDLE, total_votes unchanged.
REQ-037 poll_close during DEBOUNCE -> CLOSED, no vote; subsequent ballot_issue ignored; reset_n=0 -> all outputs 0.

Source files
------------

// File: rtl/evm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : evm_pkg
// Description : Shared types and constants for the ballot unit: FSM state
//               encoding, candidate count/width, vote counter width and
//               small one-hot helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package evm_pkg;

    localparam int NUM_CAND   = 4;
    localparam int CAND_W     = 2;
    localparam int VOTE_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        DEBOUNCE = 3'd2,
        COMMIT   = 3'd3,
        RELEASE  = 3'd4,
        CLOSED   = 3'd5
    } state_t;

    // True when exactly one candidate button is pressed
    function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
        int n;
        n = 0;
        for (int k = 0; k < NUM_CAND; k++) begin
            if (v[k]) n = n + 1;
        end
        return (n == 1);
    endfunction

    // Index of the (single) set bit; only meaningful when is_onehot() holds
    function automatic logic [CAND_W-1:0] onehot_idx(input logic [NUM_CAND-1:0] v);
        logic [CAND_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_CAND; k++) begin
            if (v[k]) idx = CAND_W'(k);
        end
        return idx;
    endfunction

    // Button mask that corresponds to a latched candidate index
    function automatic logic [NUM_CAND-1:0] sel_mask(input logic [CAND_W-1:0] idx);
        return NUM_CAND'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync
// Description : Two-flop synchroniser for a bus of independent asynchronous
//               level inputs (each bit synchronised on its own).
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability stage followed by the stable output stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ballot_unit.sv
`default_nettype none
// ============================================================================
// Module      : ballot_unit
// Description : Voting-machine ballot unit. Opens a ballot on an officer
//               pulse, debounces a single candidate button press, hands the
//               vote to the counter with a valid/ready handshake, and blocks
//               repeat votes until the button is released.
//               Optional feature macro: BALLOT_TIMEOUT_EN (open ballots expire
//               after TIMEOUT_CYCLES and pulse timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module ballot_unit
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ballot_issue,
    input  logic [NUM_CAND-1:0]   btn,
    input  logic                  poll_close,
    input  logic                  vote_ready,
    output logic                  vote_valid,
    output logic [CAND_W-1:0]     vote_sel,
    output logic                  ballot_lamp,
    output logic                  timeout,
    output logic [VOTE_CNT_W-1:0] total_votes
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    state_t                r_state;
    logic [CAND_W-1:0]     r_sel;
    logic [DB_W-1:0]       r_db_cnt;
    logic                  r_valid;
    logic                  r_lamp;
    logic                  r_timeout;
    logic                  r_close_pend;
    logic [VOTE_CNT_W-1:0] r_total;
    logic [NUM_CAND-1:0]   w_sb;
    logic                  w_expire;
    logic                  w_sb_match;

    btn_sync #(
        .WIDTH (NUM_CAND)
    ) u_btn_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn),
        .q       (w_sb)
    );

    assign w_sb_match = (w_sb == sel_mask(r_sel));

`ifdef BALLOT_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] r_to_cnt;

    // Ballot-open timer: zero outside an open ballot, so it restarts on ARMED entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ARMED || r_state == DEBOUNCE) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_expire = (r_state == ARMED || r_state == DEBOUNCE) &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;

    // Ballots never expire in this build
    assign w_expire             = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Ballot FSM with registered handshake, lamp and timeout outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_db_cnt     <= '0;
            r_valid      <= 1'b0;
            r_lamp       <= 1'b0;
            r_timeout    <= 1'b0;
            r_close_pend <= 1'b0;
            r_total      <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (poll_close) begin
                        r_state <= CLOSED;
                        r_lamp  <= 1'b0;
                    end else if (ballot_issue) begin
                        r_state <= ARMED;
                        r_lamp  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (poll_close) begin
                        r_state <= CLOSED;
                        r_lamp  <= 1'b0;
                    end else if (w_expire) begin
                        r_state   <= IDLE;
                        r_lamp    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else if (is_onehot(w_sb)) begin
                        r_sel    <= onehot_idx(w_sb);
                        r_db_cnt <= '0;
                        r_state  <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (poll_close) begin
                        r_state <= CLOSED;
                        r_lamp  <= 1'b0;
                    end else if (w_expire) begin
                        r_state   <= IDLE;
                        r_lamp    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else if (w_sb_match) begin
                        if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                            r_state  <= COMMIT;
                            r_valid  <= 1'b1;
                            r_lamp   <= 1'b0;
                            r_db_cnt <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_W'(1);
                        end
                    end else begin
                        // Bounce or a different button: start over
                        r_state  <= ARMED;
                        r_db_cnt <= '0;
                    end
                end
                COMMIT: begin
                    // A close request during the handshake is remembered and
                    // honoured once the vote has been accepted
                    if (poll_close) r_close_pend <= 1'b1;
                    if (vote_ready) begin
                        r_valid      <= 1'b0;
                        r_close_pend <= 1'b0;
                        if (r_total != {VOTE_CNT_W{1'b1}}) begin
                            r_total <= r_total + VOTE_CNT_W'(1);
                        end
                        r_state <= (poll_close || r_close_pend) ? CLOSED : RELEASE;
                    end
                end
                RELEASE: begin
                    if (poll_close) begin
                        r_state <= CLOSED;
                    end else if (w_sb == '0) begin
                        r_state <= IDLE;
                    end
                end
                CLOSED: begin
                    r_state <= CLOSED;
                    r_valid <= 1'b0;
                    r_lamp  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_lamp  <= 1'b0;
                end
            endcase
        end
    end

    assign vote_valid  = r_valid;
    assign vote_sel    = r_sel;
    assign ballot_lamp = r_lamp;
    assign timeout     = r_timeout;
    assign total_votes = r_total;

endmodule
`default_nettype wire

// File: tb/tb_ballot_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ballot_unit
// Description : Self-checking bench for ballot_unit (DEBOUNCE_CYCLES=4,
//               TIMEOUT_CYCLES=20). A per-cycle vector table covers a clean
//               vote, release blocking and multi-hot rejection; hand-written
//               sequences cover bounce, back-pressure, timeout, poll close
//               and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ballot_unit;

    logic        clk;
    logic        reset_n;
    logic        ballot_issue;
    logic [3:0]  btn;
    logic        poll_close;
    logic        vote_ready;
    logic        vote_valid;
    logic [1:0]  vote_sel;
    logic        ballot_lamp;
    logic        timeout;
    logic [15:0] total_votes;

    int n_total;
    int n_pass;

    typedef struct {
        logic        issue;
        logic [3:0]  b;
        logic        close;
        logic        ready;
        logic        exp_valid;
        logic [1:0]  exp_sel;
        logic        exp_lamp;
        logic [15:0] exp_total;
    } vec_t;

    vec_t vt[32];

    ballot_unit #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (20)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ballot_issue (ballot_issue),
        .btn          (btn),
        .poll_close   (poll_close),
        .vote_ready   (vote_ready),
        .vote_valid   (vote_valid),
        .vote_sel     (vote_sel),
        .ballot_lamp  (ballot_lamp),
        .timeout      (timeout),
        .total_votes  (total_votes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic i, input logic [3:0] b, input logic c,
                                input logic r, input logic ev, input logic [1:0] es,
                                input logic el, input logic [15:0] et);
        vec_t v;
        v.issue = i; v.b = b; v.close = c; v.ready = r;
        v.exp_valid = ev; v.exp_sel = es; v.exp_lamp = el; v.exp_total = et;
        return v;
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        ballot_issue = 1'b0;
        btn = 4'b0000;
        poll_close = 1'b0;
        vote_ready = 1'b0;

        // issue, btn, close, ready | valid, sel, lamp, total
        vt[0]  = mk(1, 4'b0000, 0, 0, 0, 0, 1, 0);
        vt[1]  = mk(0, 4'b0100, 0, 0, 0, 0, 1, 0);
        vt[2]  = mk(0, 4'b0100, 0, 0, 0, 0, 1, 0);
        vt[3]  = mk(0, 4'b0100, 0, 0, 0, 0, 1, 0);
        vt[4]  = mk(0, 4'b0100, 0, 0, 0, 0, 1, 0);
        vt[5]  = mk(0, 4'b0100, 0, 0, 0, 0, 1, 0);
        vt[6]  = mk(0, 4'b0100, 0, 0, 0, 0, 1, 0);
        vt[7]  = mk(0, 4'b0100, 0, 0, 1, 2, 0, 0);
        vt[8]  = mk(0, 4'b0100, 0, 0, 1, 2, 0, 0);
        vt[9]  = mk(0, 4'b0100, 0, 1, 0, 0, 0, 1);
        vt[10] = mk(0, 4'b0100, 0, 0, 0, 0, 0, 1);
        vt[11] = mk(0, 4'b0000, 0, 0, 0, 0, 0, 1);
        vt[12] = mk(1, 4'b0000, 0, 0, 0, 0, 0, 1);
        vt[13] = mk(0, 4'b0000, 0, 0, 0, 0, 0, 1);
        vt[14] = mk(1, 4'b0000, 0, 0, 0, 0, 1, 1);
        vt[15] = mk(0, 4'b0011, 0, 0, 0, 0, 1, 1);
        for (int i = 16; i <= 20; i++) vt[i] = mk(0, 4'b0011, 0, 0, 0, 0, 1, 1);
        for (int i = 21; i <= 26; i++) vt[i] = mk(0, 4'b0001, 0, 0, 0, 0, 1, 1);
        vt[27] = mk(0, 4'b0001, 0, 0, 1, 0, 0, 1);
        vt[28] = mk(0, 4'b0001, 0, 1, 0, 0, 0, 2);
        for (int i = 29; i <= 31; i++) vt[i] = mk(0, 4'b0000, 0, 0, 0, 0, 0, 2);

        // Reset state
        tick();
        tick();
        chk("reset_valid", {31'd0, vote_valid}, 32'd0);
        chk("reset_lamp", {31'd0, ballot_lamp}, 32'd0);
        chk("reset_total", {16'd0, total_votes}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Clean vote, release blocking, multi-hot rejection
        for (int i = 0; i < 32; i++) begin
            ballot_issue = vt[i].issue;
            btn          = vt[i].b;
            poll_close   = vt[i].close;
            vote_ready   = vt[i].ready;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, vote_valid}, {31'd0, vt[i].exp_valid});
            chk($sformatf("vec%0d_lamp", i), {31'd0, ballot_lamp}, {31'd0, vt[i].exp_lamp});
            chk($sformatf("vec%0d_total", i), {16'd0, total_votes}, {16'd0, vt[i].exp_total});
            if (vt[i].exp_valid)
                chk($sformatf("vec%0d_sel", i), {30'd0, vote_sel}, {30'd0, vt[i].exp_sel});
        end
        ballot_issue = 1'b0;
        vote_ready   = 1'b0;

        // Bounce 1,0,1: debounce restarts, vote appears 2 cycles later than clean
        ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
        btn = 4'b0001; tick();
        chk("bounce_e1", {31'd0, vote_valid}, 32'd0);
        btn = 4'b0000; tick();
        chk("bounce_e2", {31'd0, vote_valid}, 32'd0);
        btn = 4'b0001;
        for (int k = 3; k <= 9; k++) begin
            tick();
            chk($sformatf("bounce_e%0d", k), {31'd0, vote_valid}, (k == 9) ? 32'd1 : 32'd0);
        end
        chk("bounce_sel", {30'd0, vote_sel}, 32'd0);
        vote_ready = 1'b1; tick(); vote_ready = 1'b0;
        chk("bounce_total", {16'd0, total_votes}, 32'd3);
        btn = 4'b0000;
        repeat (3) tick();

        // Back-pressure: valid/sel held while vote_ready stays low
        ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
        btn = 4'b1000;
        repeat (7) tick();
        chk("bp_valid_up", {31'd0, vote_valid}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k), {30'd0, vote_sel, vote_valid}, 32'b111);
        end
        vote_ready = 1'b1; tick(); vote_ready = 1'b0;
        chk("bp_total", {16'd0, total_votes}, 32'd4);
        // Button still held: officer pulses must not open a new ballot
        for (int k = 0; k < 8; k++) begin
            ballot_issue = k[0];
            tick();
            chk($sformatf("held_%0d", k), {30'd0, ballot_lamp, vote_valid}, 32'd0);
        end
        ballot_issue = 1'b0;
        btn = 4'b0000;
        repeat (3) tick();
        chk("held_total", {16'd0, total_votes}, 32'd4);
        ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
        chk("reissue_lamp", {31'd0, ballot_lamp}, 32'd1);

`ifdef BALLOT_TIMEOUT_EN
        // Open ballot, no press: single timeout pulse after 20 cycles
        for (int k = 1; k <= 21; k++) begin
            tick();
            chk($sformatf("to_c%0d", k), {31'd0, timeout}, (k == 20) ? 32'd1 : 32'd0);
        end
        chk("to_lamp", {31'd0, ballot_lamp}, 32'd0);
        chk("to_total", {16'd0, total_votes}, 32'd4);
`else
        // Ballot stays open indefinitely
        repeat (25) tick();
        chk("noto_timeout", {31'd0, timeout}, 32'd0);
        chk("noto_lamp", {31'd0, ballot_lamp}, 32'd1);
`endif

        // Poll close during DEBOUNCE: no vote, closed for good
        ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
        btn = 4'b0010;
        repeat (4) tick();
        chk("pc_pre_lamp", {31'd0, ballot_lamp}, 32'd1);
        poll_close = 1'b1; tick(); poll_close = 1'b0;
        chk("pc_lamp", {31'd0, ballot_lamp}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            ballot_issue = ~k[0];
            tick();
            chk($sformatf("closed_%0d", k), {30'd0, ballot_lamp, vote_valid}, 32'd0);
        end
        ballot_issue = 1'b0;
        chk("closed_total", {16'd0, total_votes}, 32'd4);

        // Asynchronous reset clears everything without waiting for an edge
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", {12'd0, total_votes, vote_sel, ballot_lamp, timeout, vote_valid}, 32'd0);
        btn = 4'b0000;
        tick();
        reset_n = 1'b1;
        tick();

        // Reset mid-COMMIT drops valid at once and does not count the vote
        ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
        btn = 4'b0100;
        repeat (7) tick();
        chk("rc_valid_up", {30'd0, vote_sel, vote_valid}, 32'b101);
        vote_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rc_valid_drop", {31'd0, vote_valid}, 32'd0);
        tick();
        vote_ready = 1'b0;
        btn = 4'b0000;
        reset_n = 1'b1;
        tick();
        chk("rc_total", {16'd0, total_votes}, 32'd0);
        chk("rc_lamp", {31'd0, ballot_lamp}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
